// File: rtl/yuv444_to_422_packer.sv
// Packs a 4:4:4 YCbCr pixel stream into 4:2:2 beats (Y plus alternating chroma).
// Define YUV422_CHROMA_AVG_EN to average pair chroma; otherwise chroma is co-sited.
module yuv444_to_422_packer #(
    parameter int unsigned DW       = 8,
    parameter bit          CB_FIRST = 1'b1
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              in_valid,
    input  logic [3*DW-1:0]   in_data,
    input  logic              in_sof,
    input  logic              in_eol,
    output logic              out_valid,
    output logic [2*DW-1:0]   out_data,
    output logic              out_sof,
    output logic              out_eol,
    output logic              out_err
);

    typedef enum logic {PhEven, PhOdd} phase_e;

    phase_e          phase_q;
    logic [DW-1:0]   y0_q, cb0_q, cr0_q;
    logic            sof0_q;
    logic            hold_valid_q;
    logic [2*DW-1:0] hold_data_q;
    logic            hold_sof_q, hold_eol_q;

    logic [DW-1:0]   y_in, cb_in, cr_in;
    logic [DW-1:0]   pair_cb, pair_cr, chroma_a, chroma_b, lone_a;
    logic            pair_odd, lone, start, resync;

`ifdef YUV422_CHROMA_AVG_EN
    function automatic logic [DW-1:0] avg(input logic [DW-1:0] a, input logic [DW-1:0] b);
        logic [DW:0] s;
        s = {1'b0, a} + {1'b0, b} + {{DW{1'b0}}, 1'b1};
        return s[DW:1];
    endfunction
`endif

    always_comb begin
        y_in  = in_data[0*DW +: DW];
        cb_in = in_data[1*DW +: DW];
        cr_in = in_data[2*DW +: DW];

        // An sof in ODD phase abandons the pending pixel and restarts as EVEN.
        pair_odd = in_valid && (phase_q == PhOdd) && !in_sof;
        lone     = in_valid && in_eol && ((phase_q == PhEven) || in_sof);
        start    = in_valid && !in_eol && ((phase_q == PhEven) || in_sof);
        resync   = in_valid && in_sof && (phase_q == PhOdd);

`ifdef YUV422_CHROMA_AVG_EN
        pair_cb = avg(cb0_q, cb_in);
        pair_cr = avg(cr0_q, cr_in);
`else
        pair_cb = cb0_q;
        pair_cr = cr0_q;
`endif
        chroma_a = CB_FIRST ? pair_cb : pair_cr;
        chroma_b = CB_FIRST ? pair_cr : pair_cb;
        lone_a   = CB_FIRST ? cb_in : cr_in;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            phase_q      <= PhEven;
            y0_q         <= '0;
            cb0_q        <= '0;
            cr0_q        <= '0;
            sof0_q       <= 1'b0;
            hold_valid_q <= 1'b0;
            hold_data_q  <= '0;
            hold_sof_q   <= 1'b0;
            hold_eol_q   <= 1'b0;
            out_valid    <= 1'b0;
            out_data     <= '0;
            out_sof      <= 1'b0;
            out_eol      <= 1'b0;
            out_err      <= 1'b0;
        end else begin
            out_err <= resync;

            if (pair_odd || lone) begin
                phase_q <= PhEven;
            end else if (start) begin
                phase_q <= PhOdd;
            end

            if (start) begin
                y0_q   <= y_in;
                cb0_q  <= cb_in;
                cr0_q  <= cr_in;
                sof0_q <= in_sof;
            end

            // The holding register is never valid in a cycle with an odd accept,
            // so the even beat and the held beat cannot collide.
            if (pair_odd) begin
                out_valid <= 1'b1;
                out_data  <= {chroma_a, y0_q};
                out_sof   <= sof0_q;
                out_eol   <= 1'b0;
            end else if (hold_valid_q) begin
                out_valid <= 1'b1;
                out_data  <= hold_data_q;
                out_sof   <= hold_sof_q;
                out_eol   <= hold_eol_q;
            end else begin
                out_valid <= 1'b0;
                out_sof   <= 1'b0;
                out_eol   <= 1'b0;
            end

            if (pair_odd) begin
                hold_valid_q <= 1'b1;
                hold_data_q  <= {chroma_b, y_in};
                hold_sof_q   <= 1'b0;
                hold_eol_q   <= in_eol;
            end else if (lone) begin
                hold_valid_q <= 1'b1;
                hold_data_q  <= {lone_a, y_in};
                hold_sof_q   <= in_sof;
                hold_eol_q   <= 1'b1;
            end else begin
                hold_valid_q <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_yuv444_to_422_packer.sv
// Scoreboard bench for yuv444_to_422_packer; expectations follow the chroma build macro.
module tb_yuv444_to_422_packer;

`ifdef YUV422_CHROMA_AVG_EN
    localparam bit AVG = 1'b1;
`else
    localparam bit AVG = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        in_valid = 1'b0;
    logic [23:0] in_data = '0;
    logic        in_sof = 1'b0;
    logic        in_eol = 1'b0;
    logic        out_valid;
    logic [15:0] out_data;
    logic        out_sof;
    logic        out_eol;
    logic        out_err;

    yuv444_to_422_packer #(
        .DW       (8),
        .CB_FIRST (1'b1)
    ) dut (
        .clk       (clk),
        .rstn      (rstn),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_sof    (in_sof),
        .in_eol    (in_eol),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_sof   (out_sof),
        .out_eol   (out_eol),
        .out_err   (out_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         cyc;
        logic [7:0] y;
        logic [7:0] c;
        logic       sof;
        logic       eol;
    } beat_t;

    beat_t q[$];
    int    eq[$];
    int    cyc = 0;
    int    drv_cyc = 0;
    int    checks = 0;
    int    errors = 0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic int pick(input int avg_val, input int cosited_val);
        return AVG ? avg_val : cosited_val;
    endfunction

    task automatic pix(input int y, input int cb, input int cr, input bit sof, input bit eol);
        drv_cyc  = cyc;
        in_valid = 1'b1;
        in_data  = {cr[7:0], cb[7:0], y[7:0]};
        in_sof   = sof;
        in_eol   = eol;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_sof   = 1'b0;
        in_eol   = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic expect_beat(input int lat, input int y, input int c, input bit sof,
                               input bit eol);
        beat_t b;
        b.cyc = drv_cyc + lat;
        b.y   = y[7:0];
        b.c   = c[7:0];
        b.sof = sof;
        b.eol = eol;
        q.push_back(b);
    endtask

    always @(negedge clk) begin
        if (out_valid) begin
            checks++;
            if (q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_beat cyc=%0d y=%0d c=%0d sof=%0b eol=%0b", cyc,
                         out_data[7:0], out_data[15:8], out_sof, out_eol);
            end else begin
                beat_t e;
                e = q.pop_front();
                if (cyc != e.cyc || out_data[7:0] != e.y || out_data[15:8] != e.c ||
                    out_sof != e.sof || out_eol != e.eol) begin
                    errors++;
                    $display("FAIL beat got cyc=%0d y=%0d c=%0d sof=%0b eol=%0b exp cyc=%0d y=%0d c=%0d sof=%0b eol=%0b",
                             cyc, out_data[7:0], out_data[15:8], out_sof, out_eol,
                             e.cyc, e.y, e.c, e.sof, e.eol);
                end
            end
        end
        if (out_err) begin
            checks++;
            if (eq.size() == 0) begin
                errors++;
                $display("FAIL unexpected_err cyc=%0d", cyc);
            end else begin
                int ec;
                ec = eq.pop_front();
                if (cyc != ec) begin
                    errors++;
                    $display("FAIL err_timing got cyc=%0d exp cyc=%0d", cyc, ec);
                end
            end
        end
    end

    initial begin
        // Reset: 3 cycles low, then outputs must be zero with no input.
        repeat (3) @(posedge clk);
        #1;
        rstn = 1'b1;
        idle(2);
        checks++;
        if ({out_valid, out_data, out_sof, out_eol, out_err} != 20'd0) begin
            errors++;
            $display("FAIL reset_outputs got v=%0b d=%0h sof=%0b eol=%0b err=%0b exp all 0",
                     out_valid, out_data, out_sof, out_eol, out_err);
        end

        // Continuous 4-pixel line.
        pix(10, 100, 50, 1'b1, 1'b0);
        pix(20, 101, 52, 1'b0, 1'b0);
        expect_beat(1, 10, pick(101, 100), 1'b1, 1'b0);
        expect_beat(2, 20, pick(51, 50), 1'b0, 1'b0);
        pix(30, 0, 7, 1'b0, 1'b0);
        pix(40, 255, 8, 1'b0, 1'b1);
        expect_beat(1, 30, pick(128, 0), 1'b0, 1'b0);
        expect_beat(2, 40, pick(8, 7), 1'b0, 1'b1);
        idle(4);

        // 3-pixel line immediately followed by a 2-pixel line.
        pix(50, 60, 70, 1'b1, 1'b0);
        pix(52, 62, 71, 1'b0, 1'b0);
        expect_beat(1, 50, pick(61, 60), 1'b1, 1'b0);
        expect_beat(2, 52, pick(71, 70), 1'b0, 1'b0);
        pix(54, 64, 74, 1'b0, 1'b1);
        expect_beat(2, 54, 64, 1'b0, 1'b1);
        pix(80, 90, 91, 1'b0, 1'b0);
        pix(82, 92, 93, 1'b0, 1'b1);
        expect_beat(1, 80, pick(91, 90), 1'b0, 1'b0);
        expect_beat(2, 82, pick(92, 91), 1'b0, 1'b1);
        idle(4);

        // Gap between even pixel and its partner.
        pix(5, 10, 20, 1'b0, 1'b0);
        idle(5);
        pix(6, 12, 22, 1'b0, 1'b1);
        expect_beat(1, 5, pick(11, 10), 1'b0, 1'b0);
        expect_beat(2, 6, pick(21, 20), 1'b0, 1'b1);
        idle(4);

        // Resync: sof while a pixel is pending.
        pix(100, 1, 2, 1'b1, 1'b0);
        pix(110, 3, 5, 1'b1, 1'b0);
        eq.push_back(drv_cyc + 1);
        pix(112, 6, 8, 1'b0, 1'b1);
        expect_beat(1, 110, pick(5, 3), 1'b1, 1'b0);
        expect_beat(2, 112, pick(7, 5), 1'b0, 1'b1);
        idle(3);

        // One-pixel line and frame.
        pix(200, 33, 44, 1'b1, 1'b1);
        expect_beat(2, 200, 33, 1'b1, 1'b1);
        idle(4);

        // Reset mid-pair discards the pending pixel and restores EVEN phase.
        pix(7, 9, 9, 1'b1, 1'b0);
        rstn = 1'b0;
        idle(2);
        rstn = 1'b1;
        idle(3);
        pix(8, 10, 20, 1'b1, 1'b0);
        pix(9, 11, 21, 1'b0, 1'b1);
        expect_beat(1, 8, pick(11, 10), 1'b1, 1'b0);
        expect_beat(2, 9, pick(21, 20), 1'b0, 1'b1);

        for (int i = 0; i < 20 && (q.size() != 0 || eq.size() != 0); i++) idle(1);
        idle(3);
        checks++;
        if (q.size() != 0 || eq.size() != 0) begin
            errors++;
            $display("FAIL drain pending beats=%0d errs=%0d exp 0 0", q.size(), eq.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
